// File: rtl/rop3_mode_recover.sv
// rop3_mode_recover: watches (P, S, D, Result) tuples from a ROP3 evaluator
// and rebuilds the 8-bit Mode that must have produced them. Each result bit
// pins Mode[{P[i],S[i],D[i]}]. The block flags any observation that
// contradicts what has already been learned.
//
// state   | meaning
// IDLE    | waiting for start, nothing collected
// COLLECT | accepting tuples and merging learned Mode bits
// DONE    | all 8 bits learned, or beat budget used up; outputs hold
// ERR     | inconsistent observation seen; pre-conflict Mode/mask hold
module rop3_mode_recover #(
  parameter int N         = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] P,
  input  logic [N-1:0] S,
  input  logic [N-1:0] D,
  input  logic [N-1:0] Result,
  output logic [7:0]   Mode,
  output logic [7:0]   known_mask,
  output logic         done,
  output logic         complete,
  output logic         conflict
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE, ERR} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  beat_cnt, cnt_nxt, cnt_inc;
  logic [7:0]     mode_nxt, mask_nxt;
  logic           ready_nxt, done_nxt, complete_nxt, conflict_nxt;

  logic [2:0]     k;
  logic [7:0]     beat_mask, beat_val, merged_mask, merged_mode;
  logic           beat_bad, accept;

  // Decode one beat: which Mode bits it pins, their values, and whether it
  // contradicts learned bits or itself.
  always_comb begin
    k         = '0;
    beat_mask = '0;
    beat_val  = '0;
    beat_bad  = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = {P[i], S[i], D[i]};
      if (known_mask[k] && (Mode[k] != Result[i])) beat_bad = 1'b1;
      if (beat_mask[k] && (beat_val[k] != Result[i])) beat_bad = 1'b1;
      beat_mask[k] = 1'b1;
      beat_val[k]  = Result[i];
    end
  end

  assign merged_mask = known_mask | beat_mask;
  assign merged_mode = (Mode & ~beat_mask) | beat_val;
  assign accept      = in_valid && in_ready && (state == COLLECT);
  // Saturate so a large MAX_BEATS never wraps the counter.
  assign cnt_inc     = (beat_cnt == CW'(MAX_BEATS)) ? beat_cnt : beat_cnt + CW'(1);

  // Next-state and next-output decode; start overrides any beat on the same edge.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = beat_cnt;
    mode_nxt     = Mode;
    mask_nxt     = known_mask;
    ready_nxt    = in_ready;
    done_nxt     = done;
    complete_nxt = complete;
    conflict_nxt = conflict;
    if (start) begin
      state_nxt    = COLLECT;
      cnt_nxt      = '0;
      mode_nxt     = '0;
      mask_nxt     = '0;
      ready_nxt    = 1'b1;
      done_nxt     = 1'b0;
      complete_nxt = 1'b0;
      conflict_nxt = 1'b0;
    end else if (accept) begin
      cnt_nxt = cnt_inc;
      if (beat_bad) begin
        state_nxt    = ERR;
        ready_nxt    = 1'b0;
        done_nxt     = 1'b1;
        conflict_nxt = 1'b1;
      end else begin
        mode_nxt = merged_mode;
        mask_nxt = merged_mask;
        if (merged_mask == 8'hFF) begin
          state_nxt    = DONE;
          ready_nxt    = 1'b0;
          done_nxt     = 1'b1;
          complete_nxt = 1'b1;
        end else if (cnt_inc == CW'(MAX_BEATS)) begin
          state_nxt = DONE;
          ready_nxt = 1'b0;
          done_nxt  = 1'b1;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      Mode       <= '0;
      known_mask <= '0;
      in_ready   <= 1'b0;
      done       <= 1'b0;
      complete   <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      state      <= state_nxt;
      beat_cnt   <= cnt_nxt;
      Mode       <= mode_nxt;
      known_mask <= mask_nxt;
      in_ready   <= ready_nxt;
      done       <= done_nxt;
      complete   <= complete_nxt;
      conflict   <= conflict_nxt;
    end
  end

endmodule

// File: doc/rop3_mode_recover.md
Name: rop3_mode_recover

Overview:
- Inverse of the ROP3 evaluator: observes streamed (P, S, D, Result) bit-vector tuples and reconstructs the 8-bit ROP3 Mode that produced them.
- Per bit i, index k = {P[i],S[i],D[i]} (P is MSB) selects Mode[k] = Result[i].
- Accumulates learned Mode bits across beats, and flags inconsistent observations.
- Sits beside the evaluator as a self-check / mode-identification unit for verification and debug.

Parameters:
- N, 4, bit-width of P, S, D, Result (N >= 1).
- MAX_BEATS, 16, accepted beats after which collection stops even if Mode is incomplete (>= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  clears learned state and begins collection; honoured in any state.
- in_valid  input  1  observation tuple valid.
- in_ready  output  1  block accepts tuple (registered; 1 only in COLLECT).
- P  input  N  pattern operand.
- S  input  N  source operand.
- D  input  N  destination operand.
- Result  input  N  observed ROP3 output.
- Mode  output  8  learned Mode value; unknown bits read 0.
- known_mask  output  8  bit k = 1 when Mode[k] has been learned.
- done  output  1  collection finished (DONE or ERR state).
- complete  output  1  known_mask == 8'hFF and no conflict.
- conflict  output  1  inconsistent observation detected.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-low; the clock port is clk and the reset port is rst_n.
- Reset values: state = IDLE; Mode, known_mask and beat count = 0; in_ready, done, complete and conflict = 0. All outputs are registers.
- FSM states: IDLE, COLLECT, DONE, ERR.
- IDLE: in_ready = 0. start -> COLLECT, with Mode, known_mask, conflict and beat count cleared on the same edge.
- COLLECT: in_ready = 1. A beat is accepted on an edge with in_valid & in_ready. On the accepting edge:
  - For each i, k = {P[i],S[i],D[i]}. Conflict if known_mask[k] = 1 and Mode[k] != Result[i].
  - Conflict also if two bits within the same beat map to the same k with different Result values.
  - Otherwise set known_mask[k] = 1 and Mode[k] = Result[i] for every i.
  - Beat count += 1 (saturating).
  - Next-state priority on that same edge: conflict -> ERR; else merged mask == 8'hFF -> DONE with complete = 1; else beat count == MAX_BEATS -> DONE with complete = 0; else stay in COLLECT.
  - Latency: results visible the cycle after the accepting edge, with in_ready already 0 when leaving COLLECT.
- Conflicting beat: Mode and known_mask are not updated, so they hold their pre-conflict values. conflict = 1 and done = 1.
- DONE / ERR: outputs hold and in_ready = 0. in_valid is ignored.
- start in any state, including mid-collection, restarts: clear, then COLLECT. start has priority over a beat presented on the same edge, and that beat is discarded.
- Beats whose indices are already known and consistent are legal and change nothing except the beat count.
- Asserting rst_n low mid-operation returns immediately to reset values, with no partial update.

Test Plan:
- Mode 0xF0 (N=4): start. Beat1 P=0000, S=0011, D=0101, Result=0000 (indices 3,2,1,0). Beat2 P=1111, same S/D, Result=1111 (indices 7..4). -> After beat2: Mode=0xF0, known_mask=0xFF, done=1, complete=1, conflict=0, in_ready=0.
- Mode 0x96: same P/S/D beats with Result=0110 then 1001. -> Mode=0x96, complete=1. After beat1 only: known_mask=0x0F, Mode=0x06, done=0.
- Cross-beat conflict: beat1 as above with Result=0000, then the same beat with Result=0001. -> Cycle after beat2: conflict=1, done=1, complete=0, known_mask=0x0F, Mode=0x00.
- Intra-beat conflict: P=S=D=0000, Result=0001. -> conflict=1, done=1 after one beat, known_mask=0x00.
- Timeout: 16 beats of P=S=D=0000, Result=0000 with in_valid held high. -> Stays in COLLECT for 15 beats. After beat 16: done=1, complete=0, known_mask=0x01, Mode=0x00, in_ready=0.
- Restart and reset: start pulsed after beat1 of the Mode 0xF0 sequence -> known_mask=0, in_ready=1. rst_n low mid-collection -> all outputs 0 asynchronously; re-running the first scenario then passes.
